nes_flash_rd_ctrl: RTL and testbench

- Flash-side responder for the console mapper's flash read requests.
- Takes the 23-bit flash address issued by the mapper and sequences the external 8-bit parallel NOR flash pins: power-up reset pulse, chip/output enable, and the access wait-state count.
- Captures the data into a holding register and returns it with a valid pulse.
- Keeps a single-entry address tag so repeated reads of the same byte do not re-access the flash.

---
 rtl/nes_flash_pkg.sv | 16 +
 rtl/nes_flash_rd_ctrl.sv | 148 ++++++++++++++
 tb/tb_nes_flash_rd_ctrl.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/nes_flash_pkg.sv
// Shared constants for the mapper-side flash read controller: bus widths,
// default timing and the controller state encoding.
package nes_flash_pkg;

  localparam int FL_ADDR_W      = 23;
  localparam int FL_DATA_W      = 8;
  localparam int FL_ACC_CYC_DEF = 4;
  localparam int FL_RST_CYC_DEF = 8;

  typedef logic [1:0] fl_state_t;

  localparam fl_state_t ST_RST_HOLD = 2'd0;
  localparam fl_state_t ST_IDLE     = 2'd1;
  localparam fl_state_t ST_ACCESS   = 2'd2;

endpackage

// File: rtl/nes_flash_rd_ctrl.sv
// Flash-side responder for mapper read requests: sequences the NOR flash pins,
// captures the byte and serves repeat reads of the same byte from a one-entry tag.
module nes_flash_rd_ctrl
  import nes_flash_pkg::*;
#(
  parameter int ADDR_W  = FL_ADDR_W,
  parameter int DATA_W  = FL_DATA_W,
  parameter int ACC_CYC = FL_ACC_CYC_DEF,
  parameter int RST_CYC = FL_RST_CYC_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_en,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic              i_inval,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_rdata_vld,
  output logic              o_busy,
  output logic [ADDR_W-1:0] o_fl_addr,
  input  logic [DATA_W-1:0] i_fl_dq,
  output logic              o_fl_ce_n,
  output logic              o_fl_oe_n,
  output logic              o_fl_we_n,
  output logic              o_fl_rst_n
);

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] RST_LOAD = CNT_W'(RST_CYC - 1);
  localparam logic [CNT_W-1:0] ACC_LOAD = CNT_W'(ACC_CYC - 1);

  fl_state_t         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] tag_q, tag_d;
  logic              tag_vld_q, tag_vld_d;
  logic              inval_pend_q, inval_pend_d;
  logic [DATA_W-1:0] rdata_d;
  logic [ADDR_W-1:0] fl_addr_d;
  logic              rdata_vld_d, ce_n_d, oe_n_d, rst_n_d;
  logic              hit;

  assign o_fl_we_n = 1'b1;

  // A pending invalidate outranks a same-cycle hit so the request falls through to a miss.
  assign hit = i_req_en && tag_vld_q && (i_req_addr == tag_q) && !i_inval;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= ST_RST_HOLD;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RST_HOLD: if (cnt_q == '0) state_d = ST_IDLE;
      ST_IDLE:     if (i_req_en && !hit) state_d = ST_ACCESS;
      ST_ACCESS:   if (cnt_q == '0) state_d = ST_IDLE;
      default:     state_d = ST_RST_HOLD;
    endcase
  end

  // Output and datapath next values.
  // NOTE: every signal gets a default first so no path leaves one unassigned,
  // which is what would otherwise infer a latch.
  always_comb begin
    cnt_d        = cnt_q;
    tag_d        = tag_q;
    tag_vld_d    = tag_vld_q;
    inval_pend_d = inval_pend_q;
    rdata_d      = o_rdata;
    rdata_vld_d  = 1'b0;
    fl_addr_d    = o_fl_addr;
    ce_n_d       = o_fl_ce_n;
    oe_n_d       = o_fl_oe_n;
    rst_n_d      = o_fl_rst_n;
    case (state_q)
      ST_RST_HOLD: begin
        if (cnt_q == '0) begin
          rst_n_d = 1'b1;
          cnt_d   = RST_LOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_IDLE: begin
        if (i_inval) tag_vld_d = 1'b0;
        if (hit) begin
          rdata_vld_d = 1'b1;
        end else if (i_req_en) begin
          fl_addr_d    = i_req_addr;
          tag_d        = i_req_addr;
          tag_vld_d    = 1'b0;
          inval_pend_d = 1'b0;
          ce_n_d       = 1'b0;
          oe_n_d       = 1'b0;
          cnt_d        = ACC_LOAD;
        end
      end
      ST_ACCESS: begin
        // An invalidate anywhere in the access must stop the fetched byte being tagged.
        if (i_inval) inval_pend_d = 1'b1;
        if (cnt_q == '0) begin
          rdata_d     = i_fl_dq;
          tag_vld_d   = !(i_inval || inval_pend_q);
          rdata_vld_d = 1'b1;
          ce_n_d      = 1'b1;
          oe_n_d      = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; flash pins come straight from flops to keep them glitch-free.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q        <= RST_LOAD;
      tag_q        <= '0;
      tag_vld_q    <= 1'b0;
      inval_pend_q <= 1'b0;
      o_rdata      <= '0;
      o_rdata_vld  <= 1'b0;
      o_busy       <= 1'b1;
      o_fl_addr    <= '0;
      o_fl_ce_n    <= 1'b1;
      o_fl_oe_n    <= 1'b1;
      o_fl_rst_n   <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      tag_q        <= tag_d;
      tag_vld_q    <= tag_vld_d;
      inval_pend_q <= inval_pend_d;
      o_rdata      <= rdata_d;
      o_rdata_vld  <= rdata_vld_d;
      o_busy       <= (state_d != ST_IDLE);
      o_fl_addr    <= fl_addr_d;
      o_fl_ce_n    <= ce_n_d;
      o_fl_oe_n    <= oe_n_d;
      o_fl_rst_n   <= rst_n_d;
    end
  end

endmodule

// File: tb/tb_nes_flash_rd_ctrl.sv
// Directed bench for nes_flash_rd_ctrl: reset hold, miss, hit, invalidate,
// mid-access address change and mid-access reset.
module tb_nes_flash_rd_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_req_en;
  logic [22:0] i_req_addr;
  logic        i_inval;
  logic [7:0]  o_rdata;
  logic        o_rdata_vld;
  logic        o_busy;
  logic [22:0] o_fl_addr;
  logic [7:0]  i_fl_dq;
  logic        o_fl_ce_n;
  logic        o_fl_oe_n;
  logic        o_fl_we_n;
  logic        o_fl_rst_n;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 i_clk = ~i_clk;

  nes_flash_rd_ctrl #(
    .ADDR_W (23),
    .DATA_W (8),
    .ACC_CYC(4),
    .RST_CYC(8)
  ) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_req_en   (i_req_en),
    .i_req_addr (i_req_addr),
    .i_inval    (i_inval),
    .o_rdata    (o_rdata),
    .o_rdata_vld(o_rdata_vld),
    .o_busy     (o_busy),
    .o_fl_addr  (o_fl_addr),
    .i_fl_dq    (i_fl_dq),
    .o_fl_ce_n  (o_fl_ce_n),
    .o_fl_oe_n  (o_fl_oe_n),
    .o_fl_we_n  (o_fl_we_n),
    .o_fl_rst_n (o_fl_rst_n)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Count edges until OE# returns high (bounded); returns the count.
  task automatic wait_access(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      n++;
      if (o_fl_oe_n) break;
    end
  endtask

  // Count edges until the flash reset pin releases (bounded); flags any vld seen.
  task automatic wait_rst_release(output int n, output logic vld_seen);
    n = 0;
    vld_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      n++;
      vld_seen |= o_rdata_vld;
      if (o_fl_rst_n) break;
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_rdata"}, 32'(o_rdata), 32'h0);
    check({tag, "_vld"},   32'(o_rdata_vld), 32'd0);
    check({tag, "_busy"},  32'(o_busy), 32'd1);
    check({tag, "_addr"},  32'(o_fl_addr), 32'h0);
    check({tag, "_ce_n"},  32'(o_fl_ce_n), 32'd1);
    check({tag, "_oe_n"},  32'(o_fl_oe_n), 32'd1);
    check({tag, "_we_n"},  32'(o_fl_we_n), 32'd1);
    check({tag, "_rst_n"}, 32'(o_fl_rst_n), 32'd0);
  endtask

  initial begin
    int   n;
    logic vld_seen;

    i_rst      = 1'b1;
    i_req_en   = 1'b0;
    i_req_addr = '0;
    i_inval    = 1'b0;
    i_fl_dq    = '0;
    tick();
    tick();
    check_reset_values("por");

    // Reset release with a request held during the hold window.
    i_rst      = 1'b0;
    i_req_en   = 1'b1;
    i_req_addr = 23'h000123;
    wait_rst_release(n, vld_seen);
    check("hold_len", 32'(n), 32'd8);
    check("hold_no_vld", 32'(vld_seen), 32'd0);
    check("hold_busy_drop", 32'(o_busy), 32'd0);
    i_req_en = 1'b0;

    // Miss to 0x008123.
    i_req_en   = 1'b1;
    i_req_addr = 23'h008123;
    i_fl_dq    = 8'hA5;
    tick();
    i_req_en = 1'b0;
    check("miss_ce", 32'(o_fl_ce_n), 32'd0);
    check("miss_oe", 32'(o_fl_oe_n), 32'd0);
    check("miss_addr", 32'(o_fl_addr), 32'h008123);
    check("miss_busy", 32'(o_busy), 32'd1);
    wait_access(n);
    check("miss_oe_len", 32'(n), 32'd4);
    check("miss_vld", 32'(o_rdata_vld), 32'd1);
    check("miss_rdata", 32'(o_rdata), 32'hA5);
    check("miss_ce_hi", 32'(o_fl_ce_n), 32'd1);
    tick();
    check("miss_vld_once", 32'(o_rdata_vld), 32'd0);

    // Hit on the same byte: data pins changed but must not be read.
    i_req_en   = 1'b1;
    i_req_addr = 23'h008123;
    i_fl_dq    = 8'h5A;
    tick();
    i_req_en = 1'b0;
    check("hit_vld", 32'(o_rdata_vld), 32'd1);
    check("hit_rdata", 32'(o_rdata), 32'hA5);
    check("hit_ce", 32'(o_fl_ce_n), 32'd1);
    check("hit_busy", 32'(o_busy), 32'd0);
    tick();
    check("hit_vld_once", 32'(o_rdata_vld), 32'd0);

    // Invalidate coinciding with a request to the tagged byte.
    i_req_en = 1'b1;
    i_inval  = 1'b1;
    tick();
    i_req_en = 1'b0;
    i_inval  = 1'b0;
    check("inval_ce", 32'(o_fl_ce_n), 32'd0);
    check("inval_no_vld", 32'(o_rdata_vld), 32'd0);
    wait_access(n);
    check("inval_oe_len", 32'(n), 32'd4);
    check("inval_vld", 32'(o_rdata_vld), 32'd1);
    check("inval_rdata", 32'(o_rdata), 32'h5A);
    tick();

    // Address change while an access is in flight.
    i_req_en   = 1'b1;
    i_req_addr = 23'h000010;
    i_fl_dq    = 8'h11;
    tick();
    check("chg_addr0", 32'(o_fl_addr), 32'h000010);
    i_req_addr = 23'h00FFFC;
    tick();
    check("chg_addr_held", 32'(o_fl_addr), 32'h000010);
    wait_access(n);
    check("chg_rest_len", 32'(n), 32'd3);
    check("chg_rdata0", 32'(o_rdata), 32'h11);
    check("chg_vld0", 32'(o_rdata_vld), 32'd1);
    tick();
    i_req_en = 1'b0;
    i_fl_dq  = 8'h33;
    check("chg_ce1", 32'(o_fl_ce_n), 32'd0);
    check("chg_addr1", 32'(o_fl_addr), 32'h00FFFC);
    check("chg_vld_gap", 32'(o_rdata_vld), 32'd0);
    wait_access(n);
    check("chg_oe_len1", 32'(n), 32'd4);
    check("chg_rdata1", 32'(o_rdata), 32'h33);
    tick();

    // Reset asserted with the access counter at 2.
    i_req_en   = 1'b1;
    i_req_addr = 23'h008123;
    i_fl_dq    = 8'h77;
    tick();
    i_req_en = 1'b0;
    tick();
    check("mid_pre_oe", 32'(o_fl_oe_n), 32'd0);
    i_rst = 1'b1;
    #1;
    check_reset_values("mid_rst");
    tick();
    check("mid_rst_no_vld", 32'(o_rdata_vld), 32'd0);
    i_rst = 1'b0;
    wait_rst_release(n, vld_seen);
    check("mid_hold_len", 32'(n), 32'd8);
    check("mid_hold_no_vld", 32'(vld_seen), 32'd0);
    i_req_en   = 1'b1;
    i_req_addr = 23'h00FFFC;
    i_fl_dq    = 8'h44;
    tick();
    i_req_en = 1'b0;
    check("post_rst_miss_ce", 32'(o_fl_ce_n), 32'd0);
    check("post_rst_no_hit", 32'(o_rdata_vld), 32'd0);
    wait_access(n);
    check("post_rst_oe_len", 32'(n), 32'd4);
    check("post_rst_rdata", 32'(o_rdata), 32'h44);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
